// File: rtl/progress_ctrl_if.sv
// Command and status bundle between the progress controller and its host.
// The host pulses start/pause/abort and reads back the registered status.
interface progress_ctrl_if;
  logic       start;
  logic       pause;
  logic       abort;
  logic [7:0] progress;
  logic       busy;
  logic       done;
  logic [1:0] state;

  modport master (
    output start, pause, abort,
    input  progress, busy, done, state
  );

  modport slave (
    input  start, pause, abort,
    output progress, busy, done, state
  );
endinterface

// File: rtl/progress_ctrl.sv
// Progress-bar sequencer: counts TICK_DIV-cycle steps up to MAX_PROGRESS,
// with start/restart, pause toggle and abort. All outputs are registered.
module progress_ctrl #(
  parameter int unsigned TICK_DIV     = 6250000,
  parameter int unsigned MAX_PROGRESS = 72
) (
  input logic            CLOCK,
  input logic            RESET,
  progress_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned    CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [7:0]     PROG_MAX  = 8'(MAX_PROGRESS);

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt, tick_cnt_d;
  logic [7:0]    progress_q, progress_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= IDLE;
      tick_cnt   <= '0;
      progress_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt   <= tick_cnt_d;
      progress_q <= progress_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // abort and start override every state; pause then pre-empts any due tick
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt;
    progress_d = progress_q;
    if (bus.abort) begin
      state_d    = IDLE;
      tick_cnt_d = '0;
      progress_d = '0;
    end else if (bus.start) begin
      state_d    = RUN;
      tick_cnt_d = '0;
      progress_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt_d = '0;
            if (progress_q >= PROG_MAX - 8'd1) begin
              progress_d = PROG_MAX;
              state_d    = DONE;
            end else begin
              progress_d = progress_q + 8'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt + CNT_ONE;
          end
        end
        PAUSE: begin
          if (bus.pause) state_d = RUN;
        end
        default: ;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == PAUSE);
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  assign bus.progress = progress_q;
  assign bus.state    = state_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_progress_ctrl.sv
// Directed bench for progress_ctrl with TICK_DIV=4, MAX_PROGRESS=72.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_progress_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  progress_ctrl_if bus ();

  progress_ctrl #(.TICK_DIV(4), .MAX_PROGRESS(72)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int pr, input int bs, input int dn);
    chk({tag, ".state"},    int'(bus.state),    st);
    chk({tag, ".progress"}, int'(bus.progress), pr);
    chk({tag, ".busy"},     int'(bus.busy),     bs);
    chk({tag, ".done"},     int'(bus.done),     dn);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; edges(1); bus.start = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.pause = 1'b1; edges(1); bus.pause = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; edges(1); bus.abort = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;

    edges(2);
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    edges(3);
    chk_all("idle_hold", 0, 0, 0, 0);

    // Full run
    pulse_start();
    chk_all("run_start", 1, 0, 1, 0);
    edges(3);
    chk("run_e3.progress", int'(bus.progress), 0);
    edges(1);
    chk("run_e4.progress", int'(bus.progress), 1);
    for (int k = 2; k <= 71; k++) begin
      edges(4);
      chk($sformatf("run_step%0d", k), int'(bus.progress), k);
    end
    chk_all("run_e284", 1, 71, 1, 0);
    edges(4);
    chk_all("run_e288", 3, 72, 0, 1);
    edges(1);
    chk_all("run_e289", 3, 72, 0, 0);

    // Restart from DONE, then restart again in RUN at progress 40
    pulse_start();
    chk_all("restart1", 1, 0, 1, 0);
    edges(160);
    chk("restart1_p40", int'(bus.progress), 40);
    pulse_start();
    chk_all("restart2", 1, 0, 1, 0);
    edges(287);
    chk_all("restart2_e287", 1, 71, 1, 0);
    edges(1);
    chk_all("restart2_done", 3, 72, 0, 1);

    pulse_pause();
    chk_all("done_pause_ignored", 3, 72, 0, 0);

    // Priority: all three commands together in RUN at progress 30
    pulse_start();
    edges(120);
    chk_all("prio_p30", 1, 30, 1, 0);
    bus.abort = 1'b1; bus.start = 1'b1; bus.pause = 1'b1;
    edges(1);
    bus.abort = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    chk_all("prio_abort", 0, 0, 0, 0);
    bus.start = 1'b1; bus.pause = 1'b1;
    edges(1);
    bus.start = 1'b0; bus.pause = 1'b0;
    chk_all("prio_start_over_pause", 1, 0, 1, 0);
    edges(3);
    chk("prio_e3.progress", int'(bus.progress), 0);
    edges(1);
    chk("prio_e4.progress", int'(bus.progress), 1);

    // Pause/resume with tick_cnt held mid-step
    pulse_start();
    edges(10);
    chk_all("pause_pre", 1, 2, 1, 0);
    pulse_pause();
    chk_all("pause_enter", 2, 2, 1, 0);
    for (int i = 0; i < 50; i++) begin
      edges(1);
      chk($sformatf("pause_hold%0d.progress", i), int'(bus.progress), 2);
      chk($sformatf("pause_hold%0d.state", i), int'(bus.state), 2);
    end
    pulse_pause();
    chk_all("pause_resume", 1, 2, 1, 0);
    edges(1);
    chk("resume_e1.progress", int'(bus.progress), 2);
    edges(1);
    chk("resume_e2.progress", int'(bus.progress), 3);

    // Pause coincident with the final tick
    pulse_start();
    edges(287);
    chk_all("bound_e287", 1, 71, 1, 0);
    pulse_pause();
    chk_all("bound_paused", 2, 71, 1, 0);
    pulse_pause();
    chk_all("bound_resume", 1, 71, 1, 0);
    edges(1);
    chk_all("bound_done", 3, 72, 0, 1);
    pulse_abort();
    chk_all("done_abort", 0, 0, 0, 0);

    // Abort while paused
    pulse_start();
    edges(9);
    pulse_pause();
    chk_all("pabort_paused", 2, 2, 1, 0);
    pulse_abort();
    chk_all("pabort_idle", 0, 0, 0, 0);

    // Reset while paused at progress 17, with start asserted alongside
    pulse_start();
    edges(68);
    chk("rst_p17", int'(bus.progress), 17);
    pulse_pause();
    chk_all("rst_paused", 2, 17, 1, 0);
    rst = 1'b1; bus.start = 1'b1;
    edges(1);
    rst = 1'b0; bus.start = 1'b0;
    chk_all("rst_mid", 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      edges(1);
      chk($sformatf("rst_idle%0d.progress", i), int'(bus.progress), 0);
      chk($sformatf("rst_idle%0d.state", i), int'(bus.state), 0);
    end
    pulse_start();
    chk_all("rst_restart", 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/progress_ctrl.md
PROGRESS_CTRL -- requirements
Module: progress_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 6250000, giving clock cycles per progress step; legal values are 2 or more.
REQ-002 The block SHALL have parameter MAX_PROGRESS, default 72, giving the terminal progress value; legal range is 2..255.
REQ-003 Port CLOCK: input, 1 bit, sole clock; all state changes on its rising edge.
REQ-004 Port RESET: input, 1 bit, synchronous active-high reset.
REQ-005 Port start: input, 1 bit, one-cycle request to begin or restart a run.
REQ-006 Port pause: input, 1 bit, one-cycle toggle between running and paused.
REQ-007 Port abort: input, 1 bit, one-cycle request to cancel and return to idle.
REQ-008 Port progress: output, 8 bits, registered progress value, 0..MAX_PROGRESS, for the progress-bar renderer.
REQ-009 Port busy: output, 1 bit, registered; high in RUN or PAUSE.
REQ-010 Port done: output, 1 bit, registered one-cycle completion pulse.
REQ-011 Port state: output, 2 bits, registered state code: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-012 The block SHALL hold an internal prescaler tick_cnt of width clog2(TICK_DIV).
- In RUN, tick_cnt increments each cycle.
- At TICK_DIV-1 it wraps to 0 and issues an internal tick.
REQ-013 On a tick, the block SHALL set progress to progress+1; progress SHALL never exceed MAX_PROGRESS.
REQ-014 Input priority within any cycle SHALL be abort > start > pause > tick.
REQ-015 From IDLE, start SHALL move to RUN with progress=0 and tick_cnt=0.
- pause and abort are ignored in IDLE.
- progress holds 0 in IDLE.
REQ-016 In RUN, abort SHALL move to IDLE with progress=0 and tick_cnt=0.
REQ-017 In RUN, start SHALL restart: stay in RUN with progress=0 and tick_cnt=0.
REQ-018 In RUN, pause SHALL move to PAUSE.
- tick_cnt and progress keep their values.
- Any tick due in that cycle is not taken.
REQ-019 In RUN, a tick that brings progress to MAX_PROGRESS SHALL move to DONE on the same edge, with tick_cnt=0.
REQ-020 In PAUSE, tick_cnt and progress SHALL hold.
- pause returns to RUN, and counting resumes from the held tick_cnt.
- start restarts per REQ-017.
- abort per REQ-016.
REQ-021 In DONE, progress SHALL hold MAX_PROGRESS.
- start restarts per REQ-017.
- abort returns to IDLE with progress=0.
- pause is ignored.
REQ-022 done SHALL be 1 exactly in the first cycle that state==DONE, and 0 otherwise.
- A restart from DONE followed by a later completion produces a new pulse.
REQ-023 busy SHALL equal (state==RUN || state==PAUSE), registered alongside state.
REQ-024 progress SHALL change by at most +1 per cycle, except for the reset-to-0 cases in REQ-015, REQ-016, REQ-017 and REQ-021.
REQ-025 All outputs SHALL be glitch-free registers; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 When RESET=1 at a clock edge, the block SHALL set state=IDLE, progress=0, tick_cnt=0, busy=0, done=0; all inputs are ignored that cycle.
REQ-027 RESET asserted mid-run or while paused SHALL produce the REQ-026 values on the next edge; a start is then required to run again.

Verification (TICK_DIV=4, MAX_PROGRESS=72 unless stated)
REQ-028 Full run: start pulse at edge E, no other input.
- Required: progress=1 at E+4 and progress=k at E+4k.
- At E+288: progress=72, state=3, done=1 for one cycle, busy=0.
REQ-029 Pause/resume: start, run 10 cycles (progress=2, tick_cnt=2), pause.
- Hold 50 cycles: progress=2 and state=2 throughout.
- Second pause: progress becomes 3 two edges after return to RUN.
REQ-030 Priority: abort+start+pause asserted together in RUN at progress=30.
- Required: state=0, progress=0, busy=0.
- Then start+pause together in IDLE: state=1, progress=0.
REQ-031 Restart: start in DONE, then start again in RUN at progress=40.
- Required: progress=0 and state=1 after each.
- Completion 288 edges after the second start gives a second done pulse.
REQ-032 Reset mid-operation: RESET at progress=17 in PAUSE.
- Required: all outputs reset; no progress change for 100 cycles without start.
REQ-033 Boundary: pause coincident with the tick at progress=71.
- Required: state=2, progress=71, done=0.
- After resume, DONE is reached 1 edge later with progress=72.
